// File: rtl/regfile.sv
//-----------------------------------------------------------------------------
// Module   : regfile
// Brief    : Two-read / one-write general-purpose register file at the
//            write-back end of the pipeline. Register 0 is hardwired to zero.
//            Writes are clocked; reads are combinational.
// Options  : REGFILE_BYPASS_EN - when defined, a write and a read to the same
//            non-zero register in one cycle return the incoming write data
//            (same-cycle WB->ID forwarding).
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  localparam logic [ADDR_W-1:0] c_zero_addr = '0;
  localparam logic [DATA_W-1:0] c_zero_word = '0;

  // Architectural state. Entry 0 is kept as a flop that is never written so
  // the read mux stays a plain index; synthesis folds it to a constant.
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // One-hot write select, one bit per entry.
  logic [NUM_REGS-1:0] w_wr_sel;

  // A write is effective only when enabled and not targeting register 0.
  logic w_wr_valid;

  // Per-port bypass hit (forced low when the bypass option is not built).
  logic w_hit1;
  logic w_hit2;

  // Per-port stored value selected by the read address.
  logic [DATA_W-1:0] w_stored1;
  logic [DATA_W-1:0] w_stored2;

  assign w_wr_valid = we && (waddr != c_zero_addr);

  // Register 0 never receives a write.
  assign w_wr_sel[0] = 1'b0;

  // Address decode for every writable entry.
  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_wr_dec
      assign w_wr_sel[gi] = w_wr_valid && (waddr == ADDR_W'(gi));
    end
  endgenerate

  // Next-state: the selected entry takes wdata, all others hold.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = w_wr_sel[i] ? wdata : regs_q[i];
    end
  end

  // Storage update; reset clears every entry immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= c_zero_word;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Same-cycle forwarding: a read matching the in-flight write sees wdata.
  assign w_hit1 = w_wr_valid && re1 && (raddr1 == waddr);
  assign w_hit2 = w_wr_valid && re2 && (raddr2 == waddr);
`else
  // No forwarding: a read always returns the value stored before this edge.
  assign w_hit1 = 1'b0;
  assign w_hit2 = 1'b0;
`endif

  assign w_stored1 = regs_q[raddr1];
  assign w_stored2 = regs_q[raddr2];

  // Read-port priority: reset, read enable, register 0, bypass, storage.
  function automatic logic [DATA_W-1:0] port_value(
    input logic              in_rst,
    input logic              in_re,
    input logic [ADDR_W-1:0] in_raddr,
    input logic              in_hit,
    input logic [DATA_W-1:0] in_bypass,
    input logic [DATA_W-1:0] in_stored
  );
    logic [DATA_W-1:0] v;
    v = c_zero_word;
    if (in_rst) begin
      v = c_zero_word;
    end else if (!in_re) begin
      v = c_zero_word;
    end else if (in_raddr == c_zero_addr) begin
      v = c_zero_word;
    end else if (in_hit) begin
      v = in_bypass;
    end else begin
      v = in_stored;
    end
    return v;
  endfunction

  // Read port 1, combinational.
  always_comb begin
    rdata1 = port_value(rst, re1, raddr1, w_hit1, wdata, w_stored1);
  end

  // Read port 2, combinational and independent of port 1.
  always_comb begin
    rdata2 = port_value(rst, re2, raddr2, w_hit2, wdata, w_stored2);
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile.sv
//-----------------------------------------------------------------------------
// Module   : tb_regfile
// Brief    : Directed self-checking bench for regfile. Expected read values
//            follow the bypass option when REGFILE_BYPASS_EN is defined.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  int n_total = 0;
  int n_pass  = 0;

  regfile #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .NUM_REGS(32)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re1   (re1),
    .raddr1(raddr1),
    .rdata1(rdata1),
    .re2   (re2),
    .raddr2(raddr2),
    .rdata2(rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance through one rising edge and land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Write one register over a single edge, then drop the enable.
  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    tick();
    we    = 1'b0;
  endtask

  initial begin
    logic [31:0] prev;
    logic [31:0] exp_v;

    rst    = 1'b1;
    we     = 1'b0;
    waddr  = 5'd0;
    wdata  = 32'h0;
    re1    = 1'b1;
    raddr1 = 5'd5;
    re2    = 1'b1;
    raddr2 = 5'd5;
    #1;
    check("reset_rd1", rdata1, 32'h0000_0000);
    check("reset_rd2", rdata2, 32'h0000_0000);

    @(negedge clk);
    rst = 1'b0;

    // Populate reg 5, then assert reset between edges.
    write_reg(5'd5, 32'h1234_5678);
    #1;
    check("reg5_written", rdata1, 32'h1234_5678);
    #1 rst = 1'b1;
    #1;
    check("async_reset_rd1", rdata1, 32'h0000_0000);
    #1 rst = 1'b0;
    tick();
    #1;
    check("after_reset_reg5", rdata1, 32'h0000_0000);

    // A write attempted while reset is held must be ignored.
    @(negedge clk);
    rst   = 1'b1;
    we    = 1'b1;
    waddr = 5'd11;
    wdata = 32'hCAFE_F00D;
    tick();
    rst    = 1'b0;
    we     = 1'b0;
    raddr1 = 5'd11;
    #1;
    check("write_during_reset", rdata1, 32'h0000_0000);

    // Basic write and read on both ports.
    @(negedge clk);
    write_reg(5'd3, 32'hDEAD_BEEF);
    raddr1 = 5'd3;
    raddr2 = 5'd3;
    #1;
    check("basic_rd1", rdata1, 32'hDEAD_BEEF);
    check("basic_rd2", rdata2, 32'hDEAD_BEEF);

    // we=0 leaves storage untouched even with a live address and data.
    @(negedge clk);
    we    = 1'b0;
    waddr = 5'd3;
    wdata = 32'h0000_0000;
    tick();
    #1;
    check("we0_hold", rdata1, 32'hDEAD_BEEF);

    // Register 0 is hardwired to zero.
    @(negedge clk);
    write_reg(5'd0, 32'hFFFF_FFFF);
    raddr1 = 5'd0;
    #1;
    check("r0_hardwire", rdata1, 32'h0000_0000);

    // Read-enable gating on port 2.
    @(negedge clk);
    write_reg(5'd7, 32'hA5A5_A5A5);
    re2    = 1'b0;
    raddr2 = 5'd7;
    #1;
    check("re2_gated", rdata2, 32'h0000_0000);
    re2 = 1'b1;
    #1;
    check("re2_enabled", rdata2, 32'hA5A5_A5A5);

    // Same-cycle write/read hazard on reg 9.
    @(negedge clk);
    write_reg(5'd9, 32'h1111_1111);
    we     = 1'b1;
    waddr  = 5'd9;
    wdata  = 32'h2222_2222;
    re1    = 1'b1;
    raddr1 = 5'd9;
    re2    = 1'b0;
    raddr2 = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_v = 32'h2222_2222;
`else
    exp_v = 32'h1111_1111;
`endif
    check("hazard_before_edge", rdata1, exp_v);
    check("hazard_re2_off", rdata2, 32'h0000_0000);
    @(negedge clk);
    we  = 1'b0;
    re2 = 1'b1;
    #1;
    check("hazard_after_edge_rd1", rdata1, 32'h2222_2222);
    check("hazard_after_edge_rd2", rdata2, 32'h2222_2222);

    // Back-to-back writes to reg 10 while reading it every cycle.
    @(negedge clk);
    raddr1 = 5'd10;
    prev   = 32'h0;
    for (int k = 1; k <= 3; k++) begin
      we    = 1'b1;
      waddr = 5'd10;
      wdata = 32'(k);
      #1;
`ifdef REGFILE_BYPASS_EN
      exp_v = 32'(k);
`else
      exp_v = prev;
`endif
      check($sformatf("b2b_cycle%0d", k), rdata1, exp_v);
      tick();
      prev = 32'(k);
    end
    we = 1'b0;
    #1;
    check("b2b_final", rdata1, 32'h0000_0003);

    // Earlier entries remain intact.
    raddr1 = 5'd3;
    raddr2 = 5'd7;
    #1;
    check("retain_reg3", rdata1, 32'hDEAD_BEEF);
    check("retain_reg7", rdata2, 32'hA5A5_A5A5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/regfile.md
Name: regfile

Overview:
- General-purpose register file at the write-back end of the five-stage pipeline.
- Consumes the write triple (address, enable, data) produced by the MEM/WB pipeline register.
- Serves two independent read ports to the ID stage for operand fetch.
- Register 0 is hardwired to zero.
- Writes are clocked. Reads are combinational, with an optional same-cycle write-to-read bypass.

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- ADDR_W, 5, width of register addresses.
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write enable from WB stage (`WriteEnable = 1).
- waddr  input  ADDR_W  write destination register (`RegAddrBus).
- wdata  input  DATA_W  write data (`RegBus).
- re1  input  1  read enable, port 1.
- raddr1  input  ADDR_W  read address, port 1.
- rdata1  output  DATA_W  read data, port 1.
- re2  input  1  read enable, port 2.
- raddr2  input  ADDR_W  read address, port 2.
- rdata2  output  DATA_W  read data, port 2.

Behaviour:
- Reset: rst asserted clears all NUM_REGS entries to `ZeroWord immediately, without waiting for a clock edge.
- While rst is high, rdata1 and rdata2 are `ZeroWord and writes are ignored.
- Reset deasserting between clock edges takes effect at the next posedge; no partial write occurs.
- Write: at posedge clk, when rst=0, we=1 and waddr!=0, regs[waddr] <= wdata. Write latency is 1 cycle; data is visible to a plain read from the cycle after the edge.
- A write with waddr=0 is discarded. regs[0] always reads 0.
- A write with we=0 leaves all entries unchanged.
- Read ports are combinational and independent. Each port is evaluated in the following priority:
  1. rst=1 -> 0.
  2. reN=0 -> 0.
  3. raddrN=0 -> 0.
  4. Bypass hit (see Optional Feature) -> wdata.
  5. Otherwise -> regs[raddrN].
- Both ports may address the same register in the same cycle; both return identical data.
- A write and both reads to the same address in one cycle are legal. Read results follow the bypass rule.
- There is no backpressure or stall input. The block accepts one write per cycle unconditionally.
- Addresses are always in range because NUM_REGS = 2**ADDR_W; there is no wrap or out-of-range case.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When rst=0, we=1, waddr!=0, reN=1 and raddrN==waddr, rdataN = wdata in the same cycle.
  - This resolves the WB->ID read-after-write hazard with zero bubbles.
- Undefined:
  - No bypass; rdataN returns the old regs[raddrN] value until the following cycle.
  - The pipeline must resolve the hazard elsewhere (stall or ID-stage forwarding).

Test Plan:
- Reset: assert rst mid-simulation after writing regs[5]=0x1234_5678, without a clock edge -> rdata1 with re1=1, raddr1=5 reads 0x0000_0000 immediately. After deassert plus one clock, still 0.
- Basic write/read: we=1, waddr=3, wdata=0xDEAD_BEEF at edge N -> from cycle N+1, re1=1, raddr1=3 gives 0xDEAD_BEEF; re2=1, raddr2=3 gives the same value.
- r0 hardwire: we=1, waddr=0, wdata=0xFFFF_FFFF -> next cycle raddr1=0, re1=1 gives 0x0000_0000.
- Read enable gating: regs[7]=0xA5A5_A5A5, re2=0, raddr2=7 -> rdata2=0. Then re2=1 -> rdata2=0xA5A5_A5A5 in the same cycle.
- Same-cycle hazard: regs[9]=0x1111_1111; in one cycle we=1, waddr=9, wdata=0x2222_2222, re1=1, raddr1=9 ->
  - With REGFILE_BYPASS_EN: rdata1=0x2222_2222 before the edge.
  - Without it: rdata1=0x1111_1111 before the edge.
  - After the edge: 0x2222_2222 in both builds.
- Back-to-back writes: writes to reg 10 of 1, 2, 3 on consecutive edges while reading raddr1=10 each cycle -> port returns the previous value each cycle (or the current wdata with bypass). The final value is 3.
